// File: rtl/univ_reg.sv
// Universal WIDTH-bit register: load, per-bit JK, masked toggle, shift left/right, up/down count.
// Latency: one clk edge for q/wrap; qb, ser_out, tc combinational. No backpressure (en=0 holds).
// Define UREG_SAT_EN to make UP/DOWN saturate at the limits (wrap then stays 0).
module univ_reg #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             sclr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             ser_out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [2:0] M_HOLD   = 3'd0;
  localparam logic [2:0] M_LOAD   = 3'd1;
  localparam logic [2:0] M_JK     = 3'd2;
  localparam logic [2:0] M_TOGGLE = 3'd3;
  localparam logic [2:0] M_SHL    = 3'd4;
  localparam logic [2:0] M_SHR    = 3'd5;
  localparam logic [2:0] M_UP     = 3'd6;
  localparam logic [2:0] M_DOWN   = 3'd7;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             all_ones;
  logic             all_zero;

  assign all_ones = &q;
  assign all_zero = ~|q;

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    case (mode)
      M_HOLD:   q_nxt = q;
      M_LOAD:   q_nxt = d;
      // Per bit: 00 hold, 01 clear, 10 set, 11 toggle.
      M_JK:     q_nxt = (j & ~q) | (~k & q);
      M_TOGGLE: q_nxt = q ^ d;
      M_SHL:    q_nxt = {q[WIDTH-2:0], ser_in};
      M_SHR:    q_nxt = {ser_in, q[WIDTH-1:1]};
      M_UP: begin
`ifdef UREG_SAT_EN
        q_nxt = all_ones ? q : q + ONE;
`else
        q_nxt    = q + ONE;
        wrap_nxt = all_ones;
`endif
      end
      M_DOWN: begin
`ifdef UREG_SAT_EN
        q_nxt = all_zero ? q : q - ONE;
`else
        q_nxt    = q - ONE;
        wrap_nxt = all_zero;
`endif
      end
      default: q_nxt = q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q    <= RESET_VAL;
      wrap <= 1'b0;
    end else if (sclr) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (!en) begin
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

  assign qb      = ~q;
  assign ser_out = (mode == M_SHL) ? q[WIDTH-1] :
                   (mode == M_SHR) ? q[0]       : 1'b0;
  assign tc      = ((mode == M_UP) && all_ones) || ((mode == M_DOWN) && all_zero);

endmodule

// File: tb/tb_univ_reg.sv
// Randomised and directed bench for univ_reg (WIDTH=8, RESET_VAL=8'hA5) against an arithmetic reference model.
module tb_univ_reg;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en = 1'b0;
  logic       sclr = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] d = 8'h00;
  logic [7:0] j = 8'h00;
  logic [7:0] k = 8'h00;
  logic       ser_in = 1'b0;
  logic [7:0] q;
  logic [7:0] qb;
  logic       ser_out;
  logic       tc;
  logic       wrap;

  int pass_cnt = 0;
  int total_cnt = 0;
  int mq = 0;
  bit mwrap = 1'b0;

  univ_reg #(.WIDTH(8), .RESET_VAL(RV)) dut (
    .clk(clk), .resetn(resetn), .en(en), .sclr(sclr), .mode(mode),
    .d(d), .j(j), .k(k), .ser_in(ser_in),
    .q(q), .qb(qb), .ser_out(ser_out), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference: value as an integer 0..255, updated by the mode rules with plain arithmetic.
  task automatic model_step();
    int r;
    int jb;
    int kb;
    int qbit;
    if (sclr) begin
      mq = 0;
      mwrap = 1'b0;
    end else if (!en) begin
      mwrap = 1'b0;
    end else begin
      mwrap = 1'b0;
      case (mode)
        3'd1: mq = int'(d);
        3'd2: begin
          r = 0;
          for (int b = 0; b < 8; b++) begin
            jb = (int'(j) >> b) & 1;
            kb = (int'(k) >> b) & 1;
            qbit = (mq >> b) & 1;
            if (jb == 1 && kb == 1) qbit = 1 - qbit;
            else if (jb == 1) qbit = 1;
            else if (kb == 1) qbit = 0;
            r = r + (qbit << b);
          end
          mq = r;
        end
        3'd3: mq = mq ^ int'(d);
        3'd4: mq = (mq * 2) % 256 + int'(ser_in);
        3'd5: mq = mq / 2 + int'(ser_in) * 128;
        3'd6: begin
          if (mq == 255) begin
`ifndef UREG_SAT_EN
            mq = 0;
            mwrap = 1'b1;
`endif
          end else mq = mq + 1;
        end
        3'd7: begin
          if (mq == 0) begin
`ifndef UREG_SAT_EN
            mq = 255;
            mwrap = 1'b1;
`endif
          end else mq = mq - 1;
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic exp_tc(int v, logic [2:0] m);
    return (m == 3'd6 && v == 255) || (m == 3'd7 && v == 0);
  endfunction

  function automatic logic exp_ser(int v, logic [2:0] m);
    if (m == 3'd4) return ((v >> 7) & 1) == 1;
    if (m == 3'd5) return (v & 1) == 1;
    return 1'b0;
  endfunction

  task automatic set_in(logic e, logic s, logic [2:0] m, logic [7:0] dd,
                        logic [7:0] jj, logic [7:0] kk, logic si);
    en = e; sclr = s; mode = m; d = dd; j = jj; k = kk; ser_in = si;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] mq8;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (q !== 8'hA5 || qb !== 8'h5A || wrap !== 1'b0)
      $display("FAIL reset_hold: q=%h qb=%h wrap=%b required q=a5 qb=5a wrap=0", q, qb, wrap);
    else pass_cnt++;
    resetn = 1'b1;
    mq = int'(RV);
    mwrap = 1'b0;
    set_in(1'b1, 1'b0, 3'd1, 8'h33, 8'h00, 8'h00, 1'b0);
    tick();
    mq8 = mq[7:0];
    total_cnt++;
    if (q !== mq8) $display("FAIL reset_first_load: q=%h required %h", q, mq8);
    else pass_cnt++;
    #2 resetn = 1'b0;
    #1;
    mq = int'(RV);
    total_cnt++;
    if (q !== 8'hA5 || qb !== 8'h5A || wrap !== 1'b0)
      $display("FAIL reset_async: q=%h qb=%h wrap=%b required q=a5 qb=5a wrap=0", q, qb, wrap);
    else pass_cnt++;
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_count_wrap();
    logic [7:0] mq8;
    set_in(1'b1, 1'b0, 3'd1, 8'hFE, 8'h00, 8'h00, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 3'd6, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      mq8 = mq[7:0];
      total_cnt++;
      if (q !== mq8 || wrap !== mwrap || tc !== exp_tc(mq, mode))
        $display("FAIL count_wrap[%0d]: q=%h wrap=%b tc=%b required q=%h wrap=%b tc=%b",
                 i, q, wrap, tc, mq8, mwrap, exp_tc(mq, mode));
      else pass_cnt++;
    end
    // Wrap pulse then asynchronous reset before the next edge must clear it.
    set_in(1'b1, 1'b0, 3'd1, 8'hFF, 8'h00, 8'h00, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 3'd6, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    total_cnt++;
    if (wrap !== mwrap) $display("FAIL wrap_before_reset: wrap=%b required %b", wrap, mwrap);
    else pass_cnt++;
    #2 resetn = 1'b0;
    #1;
    mq = int'(RV);
    mwrap = 1'b0;
    total_cnt++;
    if (wrap !== 1'b0 || q !== 8'hA5)
      $display("FAIL reset_midcount: q=%h wrap=%b required q=a5 wrap=0", q, wrap);
    else pass_cnt++;
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_jk();
    set_in(1'b1, 1'b0, 3'd1, 8'hF0, 8'h00, 8'h00, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 3'd2, 8'h00, 8'h0F, 8'hFF, 1'b0);
    tick();
    total_cnt++;
    if (q !== 8'h0F) $display("FAIL jk_mixed: q=%h required 0f", q);
    else pass_cnt++;
    set_in(1'b1, 1'b0, 3'd2, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    total_cnt++;
    if (q !== 8'h0F) $display("FAIL jk_hold: q=%h required 0f", q);
    else pass_cnt++;
  endtask

  task automatic test_shift();
    set_in(1'b1, 1'b0, 3'd1, 8'h81, 8'h00, 8'h00, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 3'd4, 8'h00, 8'h00, 8'h00, 1'b0);
    #1;
    total_cnt++;
    if (ser_out !== 1'b1) $display("FAIL shl_ser_out: ser_out=%b required 1", ser_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (q !== 8'h02) $display("FAIL shl: q=%h required 02", q);
    else pass_cnt++;
    set_in(1'b1, 1'b0, 3'd5, 8'h00, 8'h00, 8'h00, 1'b1);
    tick();
    total_cnt++;
    if (q !== 8'h81 || ser_out !== 1'b1)
      $display("FAIL shr: q=%h ser_out=%b required q=81 ser_out=1", q, ser_out);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    set_in(1'b1, 1'b0, 3'd1, 8'h7F, 8'h00, 8'h00, 1'b0);
    tick();
    set_in(1'b1, 1'b1, 3'd6, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    total_cnt++;
    if (q !== 8'h00 || wrap !== 1'b0)
      $display("FAIL sclr_priority: q=%h wrap=%b required q=00 wrap=0", q, wrap);
    else pass_cnt++;
    set_in(1'b0, 1'b0, 3'd6, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (q !== 8'h00) $display("FAIL en_low_hold[%0d]: q=%h required 00", i, q);
      else pass_cnt++;
    end
  endtask

  task automatic test_down_wrap();
    logic exp_wrap;
`ifdef UREG_SAT_EN
    exp_wrap = 1'b0;
`else
    exp_wrap = 1'b1;
`endif
    set_in(1'b1, 1'b0, 3'd1, 8'h01, 8'h00, 8'h00, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 3'd7, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    total_cnt++;
    if (q !== 8'h00 || tc !== 1'b1)
      $display("FAIL down_to_zero: q=%h tc=%b required q=00 tc=1", q, tc);
    else pass_cnt++;
    tick();
    total_cnt++;
`ifdef UREG_SAT_EN
    if (q !== 8'h00 || wrap !== exp_wrap)
      $display("FAIL down_wrap: q=%h wrap=%b required q=00 wrap=%b", q, wrap, exp_wrap);
`else
    if (q !== 8'hFF || wrap !== exp_wrap)
      $display("FAIL down_wrap: q=%h wrap=%b required q=ff wrap=%b", q, wrap, exp_wrap);
`endif
    else pass_cnt++;
    set_in(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    total_cnt++;
    if (wrap !== 1'b0) $display("FAIL wrap_one_cycle: wrap=%b required 0", wrap);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] mq8;
    logic [7:0] pick [4];
    pick[0] = 8'h00; pick[1] = 8'hFF; pick[2] = 8'h01; pick[3] = 8'hFE;
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
             3'($urandom_range(0, 7)),
             ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 3)] : 8'($urandom()),
             8'($urandom()), 8'($urandom()), 1'($urandom_range(0, 1)));
      #1;
      total_cnt++;
      if (tc !== exp_tc(mq, mode) || ser_out !== exp_ser(mq, mode))
        $display("FAIL rand_comb[%0d]: tc=%b ser_out=%b required tc=%b ser_out=%b",
                 i, tc, ser_out, exp_tc(mq, mode), exp_ser(mq, mode));
      else pass_cnt++;
      tick();
      mq8 = mq[7:0];
      total_cnt++;
      if (q !== mq8 || qb !== ~mq8 || wrap !== mwrap)
        $display("FAIL rand_seq[%0d]: q=%h qb=%h wrap=%b required q=%h qb=%h wrap=%b",
                 i, q, qb, wrap, mq8, ~mq8, mwrap);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_jk();
    test_shift();
    test_priority();
    test_down_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
